// File: rtl/drive_pkg.sv
// Shared constants and types for the drive command path and the DC motor channels.
// Holds the direction codes, command bit positions, per-wheel FSM encoding and the command decoder.
package drive_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned CMD_W = 4;

  localparam logic [DIR_W-1:0] DIR_STOP = 2'b00;
  localparam logic [DIR_W-1:0] DIR_FT   = 2'b10;
  localparam logic [DIR_W-1:0] DIR_BK   = 2'b01;

  localparam int unsigned CMD_FWD   = 3;
  localparam int unsigned CMD_BWD   = 2;
  localparam int unsigned CMD_LEFT  = 1;
  localparam int unsigned CMD_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN_FT = 2'd1,
    ST_RUN_BK = 2'd2,
    ST_DEAD   = 2'd3
  } motor_state_e;

  typedef struct packed {
    logic [DIR_W-1:0] dir_l;
    logic [DIR_W-1:0] dir_r;
  } wheel_tgt_t;

  typedef struct packed {
    logic       err;
    wheel_tgt_t tgt;
  } cmd_dec_t;

  // Maps a per-wheel target code onto the run state it requests.
  function automatic motor_state_e dir_to_state(input logic [DIR_W-1:0] dir);
    motor_state_e st;
    st = ST_STOP;
    if (dir == DIR_FT) begin
      st = ST_RUN_FT;
    end else if (dir == DIR_BK) begin
      st = ST_RUN_BK;
    end
    return st;
  endfunction

  function automatic logic [DIR_W-1:0] state_to_dir(input motor_state_e st);
    logic [DIR_W-1:0] dir;
    dir = DIR_STOP;
    case (st)
      ST_RUN_FT: dir = DIR_FT;
      ST_RUN_BK: dir = DIR_BK;
      default:   dir = DIR_STOP;
    endcase
    return dir;
  endfunction

  // Turning while moving idles the inner wheel; turning at rest spins in place.
  function automatic cmd_dec_t decode_cmd(input logic [CMD_W-1:0] cmd);
    cmd_dec_t d;
    logic     fwd;
    logic     bwd;
    logic     lft;
    logic     rgt;
    d         = '0;
    fwd       = cmd[CMD_FWD];
    bwd       = cmd[CMD_BWD];
    lft       = cmd[CMD_LEFT];
    rgt       = cmd[CMD_RIGHT];
    d.tgt.dir_l = DIR_STOP;
    d.tgt.dir_r = DIR_STOP;
    if ((fwd && bwd) || (lft && rgt)) begin
      d.err = 1'b1;
    end else if (fwd) begin
      d.tgt.dir_l = lft ? DIR_STOP : DIR_FT;
      d.tgt.dir_r = rgt ? DIR_STOP : DIR_FT;
    end else if (bwd) begin
      d.tgt.dir_l = lft ? DIR_STOP : DIR_BK;
      d.tgt.dir_r = rgt ? DIR_STOP : DIR_BK;
    end else if (lft) begin
      d.tgt.dir_l = DIR_BK;
      d.tgt.dir_r = DIR_FT;
    end else if (rgt) begin
      d.tgt.dir_l = DIR_FT;
      d.tgt.dir_r = DIR_BK;
    end
    return d;
  endfunction

endpackage

// File: rtl/motor_dir_fsm.sv
// Per-wheel direction sequencer: follows the target code and inserts a
// fixed stop dead-time whenever the wheel reverses.
module motor_dir_fsm
  import drive_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] target,
  output logic [1:0] dir
);

  localparam int unsigned CNT_W = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);

  motor_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      dir_q   <= DIR_STOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Stop requests are honoured at once; only an opposite-direction target detours through DEAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        state_d = dir_to_state(target);
      end
      ST_RUN_FT: begin
        if (target == DIR_STOP) begin
          state_d = ST_STOP;
        end else if (target == DIR_BK) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_RUN_BK: begin
        if (target == DIR_STOP) begin
          state_d = ST_STOP;
        end else if (target == DIR_FT) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DEAD: begin
        if (cnt_q == '0) begin
          state_d = dir_to_state(target);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output is decoded from the next state so dir moves on the same edge as the state.
  always_comb begin
    dir_d = state_to_dir(state_d);
  end

  assign dir = dir_q;

endmodule

// File: rtl/drive_cmd_ctrl.sv
// Drive command front end: latches remote commands, decodes per-wheel targets,
// flags illegal commands and forces stop when the command link goes quiet.
module drive_cmd_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned DEAD_CYC    = 50_000,
  parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic       cmd_err,
  output logic       timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  cmd_dec_t   dec_c;
  wheel_tgt_t tgt_q, tgt_d;
  logic       cmd_err_q, cmd_err_d;
  logic       timeout_q, timeout_d;
  logic [WD_W-1:0] wd_q, wd_d;

  assign dec_c = decode_cmd(cmd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tgt_q     <= '{dir_l: DIR_STOP, dir_r: DIR_STOP};
      cmd_err_q <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      tgt_q     <= tgt_d;
      cmd_err_q <= cmd_err_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  // A command on the expiry edge takes priority, so the watchdog only fires on a truly idle cycle.
  always_comb begin
    tgt_d     = tgt_q;
    cmd_err_d = 1'b0;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    if (cmd_valid) begin
      tgt_d     = dec_c.tgt;
      cmd_err_d = dec_c.err;
      timeout_d = 1'b0;
      wd_d      = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
      if (wd_d == WD_MAX) begin
        tgt_d     = '{dir_l: DIR_STOP, dir_r: DIR_STOP};
        timeout_d = 1'b1;
      end
    end
  end

  motor_dir_fsm #(
    .DEAD_CYC (DEAD_CYC)
  ) u_fsm_l (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_q.dir_l),
    .dir    (dir_l)
  );

  motor_dir_fsm #(
    .DEAD_CYC (DEAD_CYC)
  ) u_fsm_r (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_q.dir_r),
    .dir    (dir_r)
  );

  assign cmd_err = cmd_err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Directed bench for drive_cmd_ctrl with a short dead-time and watchdog.
module tb_drive_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic [1:0] dir_l;
  logic [1:0] dir_r;
  logic       cmd_err;
  logic       timeout;

  int checks;
  int errors;

  drive_cmd_ctrl #(
    .DEAD_CYC    (4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .dir_l     (dir_l),
    .dir_r     (dir_r),
    .cmd_err   (cmd_err),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] dec_code [9] = '{4'b0000, 4'b1000, 4'b0100, 4'b0001, 4'b0010,
                               4'b1010, 4'b1001, 4'b0110, 4'b0101};
  logic [1:0] exp_l [9] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] exp_r [9] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [3:0] bad_code [3] = '{4'b1100, 4'b0011, 4'b1111};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    step();
    cmd_valid = 1'b0;
    cmd       = 4'b0000;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dir(input string tag, input logic [1:0] el, input logic [1:0] er);
    check({tag, "_l"}, {2'b00, dir_l}, {2'b00, el});
    check({tag, "_r"}, {2'b00, dir_r}, {2'b00, er});
  endtask

  task automatic go_stop();
    strobe(4'b0000);
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd       = 4'b1000;

    // Reset holds everything quiet even with a live command strobe.
    for (int i = 0; i < 3; i++) begin
      step();
      check_dir("rst_dir", 2'b00, 2'b00);
      check("rst_err", {3'b0, cmd_err}, 4'h0);
      check("rst_to", {3'b0, timeout}, 4'h0);
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'b0000;
    step();
    check_dir("post_rst", 2'b00, 2'b00);

    // Legal decode table, each from a stopped wheel pair.
    for (int i = 0; i < 9; i++) begin
      go_stop();
      strobe(dec_code[i]);
      check("dec_err", {3'b0, cmd_err}, 4'h0);
      step();
      check_dir($sformatf("dec_%0d", i), exp_l[i], exp_r[i]);
    end

    // Illegal codes while running forward stop both wheels and pulse cmd_err once.
    for (int i = 0; i < 3; i++) begin
      go_stop();
      strobe(4'b1000);
      step();
      check_dir("ill_run", 2'b10, 2'b10);
      strobe(bad_code[i]);
      check($sformatf("ill_err1_%0d", i), {3'b0, cmd_err}, 4'h1);
      step();
      check($sformatf("ill_err0_%0d", i), {3'b0, cmd_err}, 4'h0);
      check_dir($sformatf("ill_dir_%0d", i), 2'b00, 2'b00);
    end

    // Full reversal: four cycles of stop, then backward.
    go_stop();
    strobe(4'b1000);
    step();
    check_dir("rev_ft", 2'b10, 2'b10);
    strobe(4'b0100);
    check_dir("rev_hold", 2'b10, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check_dir($sformatf("rev_dead_%0d", i), 2'b00, 2'b00);
    end
    step();
    check_dir("rev_bk", 2'b01, 2'b01);

    // Target flips back during DEAD: the count is not restarted.
    go_stop();
    strobe(4'b1000);
    step();
    check_dir("flip_ft", 2'b10, 2'b10);
    strobe(4'b0100);
    step();
    check_dir("flip_dead0", 2'b00, 2'b00);
    strobe(4'b1000);
    check_dir("flip_dead1", 2'b00, 2'b00);
    step();
    check_dir("flip_dead2", 2'b00, 2'b00);
    step();
    check_dir("flip_dead3", 2'b00, 2'b00);
    step();
    check_dir("flip_ft_again", 2'b10, 2'b10);

    // Mixed: left keeps running forward, right reverses.
    strobe(4'b0001);
    check_dir("mix_hold", 2'b10, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check_dir($sformatf("mix_dead_%0d", i), 2'b10, 2'b00);
    end
    step();
    check_dir("mix_bk", 2'b10, 2'b01);

    // Watchdog expiry 19 edges after the last strobe, stop one cycle later.
    go_stop();
    strobe(4'b1000);
    check("wd_to_clr", {3'b0, timeout}, 4'h0);
    for (int i = 0; i < 18; i++) step();
    check("wd_pre", {3'b0, timeout}, 4'h0);
    check_dir("wd_pre_dir", 2'b10, 2'b10);
    step();
    check("wd_fire", {3'b0, timeout}, 4'h1);
    check_dir("wd_fire_dir", 2'b10, 2'b10);
    step();
    check_dir("wd_stop_dir", 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) step();
    check("wd_sticky", {3'b0, timeout}, 4'h1);
    check_dir("wd_sticky_dir", 2'b00, 2'b00);

    // A strobe landing on the expiry edge wins and restarts the watchdog.
    strobe(4'b1000);
    check("wd_clr", {3'b0, timeout}, 4'h0);
    for (int i = 0; i < 18; i++) step();
    strobe(4'b1000);
    check("wd_race", {3'b0, timeout}, 4'h0);
    step();
    check("wd_race_next", {3'b0, timeout}, 4'h0);
    check_dir("wd_race_dir", 2'b10, 2'b10);
    for (int i = 0; i < 17; i++) step();
    check("wd_restart_pre", {3'b0, timeout}, 4'h0);
    step();
    check("wd_restart_fire", {3'b0, timeout}, 4'h1);

    // Reset mid-DEAD, then a backward command runs with no dead-time.
    strobe(4'b1000);
    step();
    check_dir("rd_ft", 2'b10, 2'b10);
    strobe(4'b0100);
    step();
    step();
    check_dir("rd_dead", 2'b00, 2'b00);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_dir("rd_rst", 2'b00, 2'b00);
    check("rd_to", {3'b0, timeout}, 4'h0);
    strobe(4'b0100);
    check_dir("rd_tgt", 2'b00, 2'b00);
    step();
    check_dir("rd_bk", 2'b01, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
